// File: rtl/srx_pkg.sv
// srx_pkg: shared UART receive definitions (state encodings, frame size).
// Also usable by the stx transmitter.
package srx_pkg;

  typedef enum logic [1:0] {
    RXIDLE  = 2'b00,
    RXSTART = 2'b01,
    RXDATA  = 2'b10,
    RXSTOP  = 2'b11
  } rx_state_e;

  localparam logic [3:0] BITNUM = 4'd8;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/srx_sync.sv
// srx_sync: 2-flop rxd synchronizer plus edge-detect flop, all reset to 1.
// Ports: clk, rst_n, rxd (async in), rxd_s (synced), fall_pulse (1->0 edge).
module srx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall_pulse
);

  logic       s1_q;
  logic       s2_q;
  logic       rxd_s_d_q;
  logic [1:0] live_q;
  logic       arm_q;

  // live_q[1] marks s2_q as holding a real pin sample rather than the
  // reset preset; arm_q then waits for a real high so a line that is
  // already low when reset lifts is never mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      rxd_s_d_q <= 1'b1;
      live_q    <= 2'b00;
      arm_q     <= 1'b0;
    end else begin
      s1_q      <= rxd;
      s2_q      <= s1_q;
      rxd_s_d_q <= s2_q;
      live_q    <= {live_q[0], 1'b1};
      if (live_q[1] && s2_q)
        arm_q <= 1'b1;
    end
  end

  assign rxd_s      = s2_q;
  assign fall_pulse = arm_q & rxd_s_d_q & ~s2_q;

endmodule

// File: rtl/srx.sv
// srx: 8N1 UART receiver, LSB first, DIVBAUD clk per bit.
// Ports: clk, rst_n, rxd -> rx_data, rx_valid, rx_frame_err. Macro SRX_MAJORITY_EN.
module srx
  import srx_pkg::*;
#(
  parameter logic [15:0] DIVBAUD = 16'd234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam logic [15:0] HALFBAUD = DIVBAUD >> 1;
  localparam logic [2:0]  LASTBIT  = 3'(BITNUM - 4'd1);
  localparam logic [15:0] BIT_PT   = DIVBAUD - 16'd1;

  logic rxd_s;
  logic fall;
  logic smp;

  srx_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rxd_s      (rxd_s),
    .fall_pulse (fall)
  );

`ifdef SRX_MAJORITY_EN
  // Start bit decides one cycle late; the data/stop grid is then anchored
  // one cycle later too, so BIT_PT lands on T+1 of every following bit.
  localparam logic [15:0] START_PT = HALFBAUD;

  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hist_q <= 2'b11;
    else
      hist_q <= {hist_q[0], rxd_s};
  end

  assign smp = maj3(hist_q[1], hist_q[0], rxd_s);
`else
  localparam logic [15:0] START_PT = HALFBAUD - 16'd1;

  assign smp = rxd_s;
`endif

  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shreg_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RXIDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        RXIDLE: begin
          cnt_q <= '0;
          if (fall)
            state_q <= RXSTART;
        end
        RXSTART: begin
          if (cnt_q == START_PT) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= smp ? RXIDLE : RXDATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RXDATA: begin
          if (cnt_q == BIT_PT) begin
            cnt_q   <= '0;
            shreg_q <= {smp, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == LASTBIT)
              state_q <= RXSTOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RXSTOP: begin
          if (cnt_q == BIT_PT) begin
            cnt_q   <= '0;
            state_q <= RXIDLE;
            if (smp) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= RXIDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_srx.sv
// tb_srx: directed bench for srx at DIVBAUD=16.
// Drives serial frames on rxd and checks pulses/data.
module tb_srx;
  import srx_pkg::*;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  srx #(.DIVBAUD(16'd16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nval = 0;
  int nerr = 0;
  int nboth = 0;
  int vcyc = 0;
  logic [7:0] got[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      got.push_back(rx_data);
      nval = nval + 1;
      vcyc = cyc;
    end
    if (rx_frame_err) nerr = nerr + 1;
    if (rx_valid && rx_frame_err) nboth = nboth + 1;
  end

  task clr_mon;
    got.delete();
    nval = 0;
    nerr = 0;
  endtask

  task drive_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task send_frame(input logic [7:0] b, input logic stopv);
    drive_bit(1'b0, BT);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BT);
    drive_bit(stopv, BT);
  endtask

  // Each interior edge is displaced by -1, 0 or +1 clk from its ideal spot.
  task send_frame_j(input logic [7:0] b);
    logic [9:0] bits;
    int jp;
    int jn;
    bits = {1'b1, b, 1'b0};
    jp = 0;
    for (int k = 0; k < 10; k++) begin
      jn = (k == 9) ? 0 : int'($urandom_range(2)) - 1;
      drive_bit(bits[k], BT + jn - jp);
      jp = jn;
    end
  endtask

  task test_reset;
    rst_n = 1'b0;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got=%h/%b/%b exp=00/0/0", rx_data, rx_valid, rx_frame_err);
    end
    checks++;
    if (dut.state_q !== RXIDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, RXIDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_mon();
    drive_bit(1'b0, 40);
    checks++;
    if (nval !== 0 || nerr !== 0 || dut.state_q !== RXIDLE) begin
      failures++;
      $display("FAIL low_at_reset_exit got=v%0d e%0d s%0d exp=v0 e0 s0", nval, nerr, dut.state_q);
    end
    drive_bit(1'b1, 20);
  endtask

  task test_basic;
    int t0;
    clr_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    drive_bit(1'b1, 8);
    checks++;
    if (nval !== 1 || got.size() != 1) begin
      failures++;
      $display("FAIL a5_count got=%0d exp=1", nval);
    end else begin
      checks++;
      if (got[0] !== 8'hA5) begin
        failures++;
        $display("FAIL a5_data got=%h exp=a5", got[0]);
      end
      checks++;
      if (vcyc - t0 < 151 || vcyc - t0 > 157) begin
        failures++;
        $display("FAIL a5_latency got=%0d exp=154+-3", vcyc - t0);
      end
    end
    checks++;
    if (nerr !== 0) begin
      failures++;
      $display("FAIL a5_err got=%0d exp=0", nerr);
    end
  endtask

  task test_frame_err;
    clr_mon();
    send_frame(8'h3C, 1'b0);
    checks++;
    if (nerr !== 1 || nval !== 0) begin
      failures++;
      $display("FAIL ferr_pulse got=e%0d v%0d exp=e1 v0", nerr, nval);
    end
    checks++;
    if (rx_data !== 8'hA5) begin
      failures++;
      $display("FAIL ferr_hold got=%h exp=a5", rx_data);
    end
    drive_bit(1'b0, 40);
    checks++;
    if (nerr !== 1 || nval !== 0) begin
      failures++;
      $display("FAIL break_quiet got=e%0d v%0d exp=e1 v0", nerr, nval);
    end
    drive_bit(1'b1, 40);
  endtask

  task test_glitch;
    clr_mon();
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);
    checks++;
    if (nval !== 0 || nerr !== 0 || dut.state_q !== RXIDLE) begin
      failures++;
      $display("FAIL glitch got=v%0d e%0d s%0d exp=v0 e0 s0", nval, nerr, dut.state_q);
    end
  endtask

  task test_back_to_back;
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h81};
    clr_mon();
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    drive_bit(1'b1, 20);
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          failures++;
          $display("FAIL b2b_data%0d got=%h exp=%h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task test_reset_mid;
    logic [7:0] b;
    b = 8'h55;
    clr_mon();
    drive_bit(1'b0, BT);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BT);
    drive_bit(b[4], 6);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00 || dut.state_q !== RXIDLE) begin
      failures++;
      $display("FAIL midrst got=%h s%0d exp=00 s0", rx_data, dut.state_q);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_bit(1'b1, 200);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, 20);
    checks++;
    if (got.size() != 1 || nerr !== 0) begin
      failures++;
      $display("FAIL midrst_count got=v%0d e%0d exp=v1 e0", got.size(), nerr);
    end else begin
      checks++;
      if (got[0] !== 8'h12) begin
        failures++;
        $display("FAIL midrst_data got=%h exp=12", got[0]);
      end
    end
  endtask

  task test_jitter_stream;
    logic [7:0] b;
    clr_mon();
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 3);
      send_frame_j(b);
    end
    drive_bit(1'b1, 20);
    checks++;
    if (got.size() != 16 || nerr !== 0) begin
      failures++;
      $display("FAIL jit_count got=v%0d e%0d exp=v16 e0", got.size(), nerr);
    end else begin
      for (int i = 0; i < 16; i++) begin
        b = 8'(i * 37 + 3);
        checks++;
        if (got[i] !== b) begin
          failures++;
          $display("FAIL jit_data%0d got=%h exp=%h", i, got[i], b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_jitter_stream();
    checks++;
    if (nboth !== 0) begin
      failures++;
      $display("FAIL exclusive got=%0d exp=0", nboth);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
